// File: rtl/codificador_scheduler_if.sv
// Request/response/converter signal bundle for codificador_scheduler.
// slave = the scheduler side, master = requesters, consumer and converter.
interface codificador_scheduler_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int W = 4 * NUM_DIGITS;

  // Valid/ready: a transfer happens on a rising edge where both valid and
  // ready are high; the source holds valid and data stable until then.
  logic         Req0_Valid;
  logic [W-1:0] Req0_Data;
  logic         Req0_Ready;
  logic         Req1_Valid;
  logic [W-1:0] Req1_Data;
  logic         Req1_Ready;
  logic         Rsp_Valid;
  logic         Rsp_Ready;
  logic [W-1:0] Rsp_Data;
  logic         Rsp_Id;
  logic         Rsp_Err;
  logic [3:0]   Enc_Input;
  logic         Enc_Ready;
  logic         Enc_Reset;
  logic [3:0]   Enc_Output;

  modport slave (
    input  Req0_Valid, Req0_Data, Req1_Valid, Req1_Data, Rsp_Ready, Enc_Output,
    output Req0_Ready, Req1_Ready, Rsp_Valid, Rsp_Data, Rsp_Id, Rsp_Err,
           Enc_Input, Enc_Ready, Enc_Reset
  );

  modport master (
    output Req0_Valid, Req0_Data, Req1_Valid, Req1_Data, Rsp_Ready, Enc_Output,
    input  Req0_Ready, Req1_Ready, Rsp_Valid, Rsp_Data, Rsp_Id, Rsp_Err,
           Enc_Input, Enc_Ready, Enc_Reset
  );
endinterface

// File: rtl/codificador_scheduler.sv
// Round-robin arbiter that streams a granted word nibble-by-nibble through one
// shared code converter and returns the assembled result with the owner's ID.
module codificador_scheduler #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  codificador_scheduler_if.slave bus,
  output logic [1:0]             o_dbg_state
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic          r_last_grant;
  logic [W-1:0]  r_work;
  logic [W-1:0]  r_result;
  logic          r_id;
  logic          r_err;
  logic          r_rsp_valid;

  logic          w_idle;
  logic          w_gnt0;
  logic          w_gnt1;
  logic [3:0]    w_digit;

  // On a tie the requester that was not served last wins.
  assign w_gnt0  = bus.Req0_Valid & (~bus.Req1_Valid | r_last_grant);
  assign w_gnt1  = bus.Req1_Valid & (~bus.Req0_Valid | ~r_last_grant);
  assign w_idle  = (r_state == S_IDLE) & Reset_n;
  assign w_digit = r_work[{r_idx, 2'b00} +: 4];

  assign bus.Req0_Ready = w_idle & w_gnt0;
  assign bus.Req1_Ready = w_idle & w_gnt1;
  assign bus.Enc_Input  = (r_state == S_CONVERT) ? w_digit : 4'd0;
  assign bus.Enc_Ready  = Reset_n & (r_state == S_CONVERT);
  assign bus.Enc_Reset  = ~Reset_n;
  assign bus.Rsp_Valid  = r_rsp_valid;
  assign bus.Rsp_Data   = r_result;
  assign bus.Rsp_Id     = r_id;
  assign bus.Rsp_Err    = r_err;
  assign o_dbg_state    = r_state;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_last_grant <= 1'b1;
      r_work       <= '0;
      r_result     <= '0;
      r_id         <= 1'b0;
      r_err        <= 1'b0;
      r_rsp_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 | w_gnt1) begin
            r_work  <= w_gnt0 ? bus.Req0_Data : bus.Req1_Data;
            r_id    <= w_gnt1;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_state <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          r_result[{r_idx, 2'b00} +: 4] <= bus.Enc_Output;
          r_err <= r_err | (w_digit > 4'd9);
          if (r_idx == LAST_IDX) begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESPOND;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_RESPOND: begin
          if (bus.Rsp_Ready) begin
            r_last_grant <= r_id;
            r_rsp_valid  <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/codificador_scheduler.md
# codificador_scheduler

Sequencing and arbitration controller for the shared 4-bit code converter (Codificador). Two requesters submit multi-digit words. The block grants one requester at a time, round-robin, and feeds the word's nibbles through the single converter instance, one digit per cycle. It assembles the converted word and returns it with the requester ID over a valid/ready response channel.

## Interface
- NUM_DIGITS, 4, nibbles per word (≥1); word width W = 4*NUM_DIGITS
- Clock  in  1  sole clock, rising edge
- Reset_n  in  1  synchronous, active-low reset
- Req0_Valid  in  1  requester 0 has a word
- Req0_Data  in  W  requester 0 word; digit i = bits [4i+3:4i]
- Req0_Ready  out  1  requester 0 word accepted this cycle
- Req1_Valid / Req1_Data / Req1_Ready  same as requester 0, for requester 1
- Rsp_Valid  out  1  result available
- Rsp_Ready  in  1  consumer accepts result
- Rsp_Data  out  W  converted word; nibble i = converter(Req digit i)
- Rsp_Id  out  1  requester that owns Rsp_Data
- Rsp_Err  out  1  at least one input digit was > 9 (non-BCD)
- Enc_Input  out  4  converter data input
- Enc_Ready  out  1  converter enable
- Enc_Reset  out  1  converter reset (active-high)
- Enc_Output  in  4  converter result (combinational from Enc_Input)

## Operation
- States: IDLE, CONVERT, RESPOND.
- IDLE:
  - Grant goes to the valid requester. If both are valid, grant goes to the one not in Last_Grant.
  - The granted requester's Req*_Ready = 1 combinationally. The other requester's ready = 0.
  - On handshake: latch Data into Work, latch the ID, set Idx = 0, clear Err_Acc, go to CONVERT.
  - With no valid request, stay in IDLE with both readies = 0.
- CONVERT:
  - Enc_Input = Work[4*Idx+3:4*Idx], Enc_Ready = 1.
  - On each edge: Result[4*Idx+3:4*Idx] <= Enc_Output, and Err_Acc |= (digit > 9).
  - If Idx == NUM_DIGITS-1, go to RESPOND. Otherwise Idx++.
- RESPOND:
  - Rsp_Valid = 1. Rsp_Data, Rsp_Id and Rsp_Err are driven from registers and held stable until handshake.
  - On Rsp_Valid & Rsp_Ready: Last_Grant <= Rsp_Id, go to IDLE.
- Outside CONVERT: Enc_Input = 0 and Enc_Ready = 0.
- Enc_Reset = ~Reset_n.
- Req*_Ready = 0 outside IDLE. Requests are not queued; a requester holds Valid and Data until its ready.
- Reset values (Reset_n = 0 at an edge):
  - State IDLE, Idx 0, Last_Grant 1 (requester 0 wins the first tie).
  - Rsp_Valid 0, Rsp_Data 0, Rsp_Id 0, Rsp_Err 0; Work and Result 0.
  - While Reset_n is low, Req*_Ready = 0 and Enc_Ready = 0.
- Reset mid-operation: the in-flight word is discarded, no response is issued, and the block is in IDLE on the first edge with Reset_n high.
- Idx width is clog2(NUM_DIGITS), minimum 1. Idx never exceeds NUM_DIGITS-1.

## Timing
- Request handshake at edge T. CONVERT occupies edges T+1 … T+NUM_DIGITS. Rsp_Valid is high from T+NUM_DIGITS through the response handshake edge.
- Minimum occupancy per word is NUM_DIGITS+2 cycles: one accept cycle, NUM_DIGITS convert cycles, one response cycle.
- Next accept is in the IDLE cycle after the response handshake. There is no accept in the same cycle as Rsp_Ready.
- Backpressure: Rsp_Ready low holds RESPOND indefinitely. Both Req*_Ready stay 0 during the stall.
- Simultaneous valids after reset: requester 0 is granted first, then requester 1, then strict alternation while both remain valid.
- A request that arrives while the block is in CONVERT or RESPOND waits. Arbitration is evaluated only in IDLE.

## Test plan
- Single word: NUM_DIGITS=4, Req0_Data=0x0000, Rsp_Ready=1 → Req0_Ready pulses once; Rsp_Valid is high exactly 4 cycles after accept, with Rsp_Data=0xEEEE, Rsp_Id=0, Rsp_Err=0.
- Digit ordering: Req1_Data=0x0101 → Rsp_Data=0xEAEA, Rsp_Id=1. Enc_Input sequence on consecutive cycles is 1,0,1,0.
- Round-robin: both valid continuously with Req0=0x1111 and Req1=0x0000 → responses in the order Id0 (0xAAAA), Id1 (0xEEEE), Id0, Id1. There are 6 cycles between successive accepts.
- Non-BCD flag: Req0_Data=0x00A0 → Rsp_Err=1. Req0_Data=0x9999 → Rsp_Err=0. Rsp_Data matches the converter model for every nibble.
- Backpressure: hold Rsp_Ready=0 for 10 cycles with Req1 valid → Rsp_Data, Rsp_Id and Rsp_Err stay stable and Req1_Ready stays 0. Releasing Rsp_Ready gives a response handshake, then IDLE, then Req1 accepted on the next cycle.
- Reset mid-convert: assert Reset_n=0 for one edge at Idx=2 → Rsp_Valid never asserts for that word, all outputs are at reset values, and a new Req0 word is accepted on the first cycle after reset release.
